// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the flappy-style score board.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      OVER    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low gfedcba patterns for digits 0..9.
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      if (d < 4'd10) return SEG_DIGIT[d];
      return SEG_BLANK;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment pattern; non-BCD values go dark.
module bcd_to_seg7
   import score_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg_c
);

   assign seg_c = seg_of(digit);

endmodule

// File: rtl/score_board.sv
// Round FSM, BCD score counter, high-score keeper and multiplexed seven-segment display.
module score_board
   import score_pkg::*;
#(
   parameter int unsigned DIGITS   = 3,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  gate,
   input  logic                  game_over,
   input  logic                  clear_high,
   input  logic                  show_high,
   output logic [4*DIGITS-1:0]   score,
   output logic [4*DIGITS-1:0]   high_score,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  new_record,
   output logic [1:0]            state
);

   localparam int unsigned W = 4 * DIGITS;

   // Reset asserts immediately, releases two clocks later.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   logic start_q, gate_q, over_q;
   logic start_e, gate_e, over_e;

   assign start_e = start & ~start_q;
   assign gate_e  = gate & ~gate_q;
   assign over_e  = game_over & ~over_q;

   logic [DIGITS-1:0] nine, gt, eq, win, zero;
   logic [W-1:0]      score_inc, disp;
   logic              all_nines, score_gt;

   assign disp = show_high ? high_score : score;

   // Per-digit increment, compare and display; carries and priorities are flat reductions.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d, h;
      logic [6:0] seg;

      assign d       = score[4*i +: 4];
      assign h       = high_score[4*i +: 4];
      assign nine[i] = (d == 4'd9);
      assign gt[i]   = (d > h);
      assign eq[i]   = (d == h);
      assign zero[i] = (disp[4*i +: 4] == 4'd0);

      if (i == 0) begin : g_lsd
         assign score_inc[3:0] = nine[0] ? 4'd0 : d + 4'd1;
      end else begin : g_upper
         assign score_inc[4*i +: 4] = (&nine[i-1:0]) ? (nine[i] ? 4'd0 : d + 4'd1) : d;
      end

      if (i == DIGITS - 1) begin : g_msd_cmp
         assign win[i] = gt[i];
      end else begin : g_low_cmp
         assign win[i] = gt[i] & (&eq[DIGITS-1:i+1]);
      end

      bcd_to_seg7 u_seg (
         .digit (disp[4*i +: 4]),
         .seg_c (seg)
      );

      if (BLANK_LZ && (i > 0)) begin : g_blank
         assign hex[7*i +: 7] = (&zero[DIGITS-1:i]) ? SEG_BLANK : seg;
      end else begin : g_show
         assign hex[7*i +: 7] = seg;
      end
   end

   assign all_nines = &nine;
   assign score_gt  = |win;

   state_t       st, st_nx;
   logic [W-1:0] score_nx, high_nx;
   logic         rec_nx;

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         score      <= '0;
         high_score <= '0;
         new_record <= 1'b0;
         start_q    <= 1'b0;
         gate_q     <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         st         <= st_nx;
         score      <= score_nx;
         high_score <= high_nx;
         new_record <= rec_nx;
         start_q    <= start;
         gate_q     <= gate;
         over_q     <= game_over;
      end
   end

   // Next state and data; game_over beats a same-cycle gate, clear_high beats a commit.
   always_comb begin
      st_nx    = st;
      score_nx = score;
      high_nx  = high_score;
      rec_nx   = new_record;
      case (st)
         IDLE, OVER: begin
            if (start_e) begin
               st_nx    = PLAYING;
               score_nx = '0;
               rec_nx   = 1'b0;
            end
         end
         PLAYING: begin
            if (over_e) begin
               st_nx = OVER;
               if (score_gt) begin
                  high_nx = score;
                  rec_nx  = 1'b1;
               end
            end else if (gate_e && !all_nines) begin
               score_nx = score_inc;
            end
         end
         default: st_nx = IDLE;
      endcase
      if (clear_high) begin
         high_nx = '0;
         rec_nx  = 1'b0;
      end
   end

endmodule
